// File: rtl/image_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_scanner_pkg
// Description : Shared definitions for the image scanner: default frame
//               geometry, pixel/coordinate widths, mask dimensions and the
//               scanner FSM state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package image_scanner_pkg;

    localparam int DEF_IMG_ROWS = 240;
    localparam int DEF_IMG_COLS = 320;
    localparam int PIX_W        = 12;
    localparam int ROW_W        = 8;
    localparam int COL_W        = 9;
    localparam int MASK_ROWS    = 3;
    localparam int MASK_COLS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage : image_scanner_pkg
`default_nettype wire

// File: rtl/image_scanner.sv
`default_nettype none
// ============================================================================
// Module      : image_scanner
// Description : Raster-scans one frame out of a frame memory (1-cycle read
//               latency) and presents each pixel with its coordinates and
//               the frame-stable mask offsets to a downstream masking stage.
// Ports       : clk, rst_n (async, active-low)
//               start                 - one-cycle frame request (IDLE only)
//               hold                  - backpressure, suppresses new reads
//               mask_row/col_offset_in- offsets latched on accepted start
//               mem_rd_en/addr/data   - frame-memory read port
//               image_pixel, pixel_row, pixel_col, pixel_valid - pixel out
//               mask_row/col_offset   - latched offsets
//               busy, done            - frame status
// Revision    : 1.0  initial release
// ============================================================================
module image_scanner
    import image_scanner_pkg::*;
#(
    parameter int IMG_ROWS = DEF_IMG_ROWS,
    parameter int IMG_COLS = DEF_IMG_COLS,
    parameter int ADDR_W   = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hold,
    input  logic [ROW_W-1:0]   mask_row_offset_in,
    input  logic [COL_W-1:0]   mask_col_offset_in,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [PIX_W-1:0]   mem_rd_data,
    output logic [PIX_W-1:0]   image_pixel,
    output logic [ROW_W-1:0]   pixel_row,
    output logic [COL_W-1:0]   pixel_col,
    output logic [ROW_W-1:0]   mask_row_offset,
    output logic [COL_W-1:0]   mask_col_offset,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(IMG_COLS - 1);

    scan_state_t        r_state;
    scan_state_t        w_next_state;

    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_addr;

    // Stage 1 of the coordinate pipeline: tags the read that is in flight
    // in the memory so its coordinates line up with mem_rd_data next cycle.
    logic               r_v1;
    logic [ROW_W-1:0]   r_row1;
    logic [COL_W-1:0]   r_col1;

    logic               w_issue;
    logic               w_last_issue;

    assign w_issue      = (r_state == ST_SCAN) && !hold;
    assign w_last_issue = w_issue && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    assign mem_rd_en    = w_issue;
    assign mem_rd_addr  = r_addr;
    assign busy         = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start)        w_next_state = ST_SCAN;
            ST_SCAN:  if (w_last_issue) w_next_state = ST_DRAIN;
            // Stage 2 is loaded from stage 1 unconditionally, so once stage 1
            // is empty the final pixel is being presented this cycle.
            ST_DRAIN: if (!r_v1)        w_next_state = ST_DONE;
            ST_DONE:                    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_row           <= '0;
            r_col           <= '0;
            r_addr          <= '0;
            mask_row_offset <= '0;
            mask_col_offset <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && start) begin
                r_row           <= '0;
                r_col           <= '0;
                r_addr          <= '0;
                mask_row_offset <= mask_row_offset_in;
                mask_col_offset <= mask_col_offset_in;
            end else if (w_issue) begin
                // Address runs alongside row/col so no multiplier is needed.
                r_addr <= r_addr + 1'b1;
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_row1      <= '0;
            r_col1      <= '0;
            pixel_valid <= 1'b0;
            image_pixel <= '0;
            pixel_row   <= '0;
            pixel_col   <= '0;
        end else begin
            r_v1 <= w_issue;
            if (w_issue) begin
                r_row1 <= r_row;
                r_col1 <= r_col;
            end
            // Registering mem_rd_data here keeps every output free of a
            // combinational path from the memory.
            pixel_valid <= r_v1;
            if (r_v1) begin
                image_pixel <= mem_rd_data;
                pixel_row   <= r_row1;
                pixel_col   <= r_col1;
            end
        end
    end

endmodule : image_scanner
`default_nettype wire

// File: doc/image_scanner.md
IMAGE_SCANNER -- requirements
Module: image_scanner

Interface
REQ-001 Parameter IMG_ROWS, default 240: number of raster rows per frame.
REQ-002 Parameter IMG_COLS, default 320: number of pixels per row.
REQ-003 Parameter ADDR_W, default 17: frame-memory word address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to scan one frame; honoured only in IDLE.
REQ-007 hold  in  1  backpressure; while high, no new read is issued.
REQ-008 mask_row_offset_in  in  8  mask row offset for the frame.
REQ-009 mask_col_offset_in  in  9  mask column offset for the frame.
REQ-010 mem_rd_en  out  1  frame-memory read strobe.
REQ-011 mem_rd_addr  out  ADDR_W  word address, row*IMG_COLS+col.
REQ-012 mem_rd_data  in  12  pixel word, valid exactly one cycle after mem_rd_en.
REQ-013 image_pixel  out  12  pixel presented to the masking stage.
REQ-014 pixel_row  out  8  row of image_pixel.
REQ-015 pixel_col  out  9  column of image_pixel.
REQ-016 mask_row_offset  out  8  frame-stable mask row offset.
REQ-017 mask_col_offset  out  9  frame-stable mask column offset.
REQ-018 pixel_valid  out  1  image_pixel/pixel_row/pixel_col are valid this cycle.
REQ-019 busy  out  1  high from accepted start until done.
REQ-020 done  out  1  one-cycle pulse after the last pixel is presented.

Function
REQ-021 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after the read for (IMG_ROWS-1, IMG_COLS-1) issues; DRAIN->DONE when the pipeline is empty; DONE->IDLE unconditionally after one cycle.
REQ-022 On accepted start: latch both mask offset inputs into the offset outputs, which hold until the next accepted start; clear row/col counters to 0.
REQ-023 start while not IDLE: ignored, no effect on the scan in progress.
REQ-024 In SCAN with hold low: assert mem_rd_en with the current address, then advance col; at col=IMG_COLS-1, col wraps to 0 and row increments.
REQ-025 In SCAN with hold high: mem_rd_en low, counters frozen; in-flight reads still complete.
REQ-026 Address arithmetic: the address is maintained as an incrementing counter (no multiplier), reset to 0 at start; it equals row*IMG_COLS+col at every issue.
REQ-027 Latency: read issued in cycle N -> pixel_valid high in cycle N+2 with image_pixel = mem_rd_data of cycle N+1 and the row/col of that read, carried through a 2-stage coordinate pipeline.
REQ-028 pixel_valid low in every cycle not matching REQ-027; outputs hold their last values when invalid.
REQ-029 Exactly IMG_ROWS*IMG_COLS valid pixels per frame, raster order, no duplicates or gaps, regardless of hold pattern.
REQ-030 done pulses in the cycle after the final pixel_valid; busy falls in that same cycle.
REQ-031 No output ever depends combinationally on mem_rd_data.

Reset
REQ-032 rst_n low: state IDLE; counters, address, and pipeline valids 0; all outputs 0, including image_pixel, pixel_row, pixel_col, both offset outputs, mem_rd_en, pixel_valid, busy, and done.
REQ-033 Reset mid-frame aborts immediately; no pixel_valid and no done until a new start after release.

Structure
REQ-034 IMG_ROWS/IMG_COLS defaults, pixel width 12, and the FSM state encoding live in the shared utils definitions alongside the mask dimensions.
REQ-035 Single module; the 2-stage coordinate/valid pipeline is plain registers, no sub-module.

Verification
REQ-036 Reset then start, hold low, 4x5 frame: 20 pixel_valid pulses in raster order; first pixel_valid 2 cycles after first mem_rd_en; done 1 cycle after the last pixel.
REQ-037 Start with offsets 10/20: offset outputs read 10/20 for the whole frame; offset inputs changed mid-frame do not affect the outputs.
REQ-038 Hold asserted for 3 cycles mid-row on a 4x5 frame: no duplicate or missing (row,col) pairs, and the total is still 20.
REQ-039 Column wrap: the pixel after (0,4) is (1,0) at address 5; the last address is 19.
REQ-040 rst_n low during SCAN: all outputs 0 asynchronously; no done follows; a fresh start rescans from (0,0).
REQ-041 Second start pulse while busy: ignored; the frame completes with exactly 20 pixels and one done.
